jump_resolve: RTL and testbench
===============================

Name: jump_resolve

Overview:
- Downstream companion of the jump/branch functional unit in the dynamically scheduled core.
- Accepts a jump/branch issue, drives the FU enable, waits the FU latency, then samples the FU outputs: jump target, link value, compare result.
- Emits a one-cycle PC redirect/flush for taken control flow; holds the link result on the writeback bus until it is acknowledged.

Parameters:
- FU_LAT, 2, cycles from the issue edge to the edge on which FU outputs are sampled (legal 1..15).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  jump/branch op presented by issue stage.
- issue_ready  out  1  block idle, can accept an op.
- issue_is_jal  in  1  op is JAL.
- issue_is_jalr  in  1  op is JALR.
- issue_is_br  in  1  op is conditional branch.
- issue_rd  in  5  destination register.
- fu_en  out  1  enable to the jump FU (combinational: issue_valid & issue_ready).
- fu_pc_jump  in  XLEN  target from FU.
- fu_pc_wb  in  XLEN  PC+4 from FU.
- fu_cmp_res  in  1  branch condition from FU.
- flush_in  in  1  kill from an older instruction (exception/mispredict).
- redirect_valid  out  1  one-cycle pulse: fetch must jump.
- redirect_pc  out  XLEN  redirect target.
- wb_valid  out  1  link result pending.
- wb_rd  out  5  link destination.
- wb_data  out  XLEN  link value.
- wb_ack  in  1  writeback bus accepted result.

Behaviour:
- Reset (async): state=IDLE; counter=0; redirect_valid=0, redirect_pc=0, wb_valid=0, wb_rd=0, wb_data=0; issue_ready=1 once out of reset.
- States: IDLE, EXEC, WB. issue_ready=1 only in IDLE.
- IDLE: on issue_valid, latch op type and rd, load counter=FU_LAT-1, go EXEC. fu_en is high that cycle only. Exactly one of the is_* flags is high; all-zero is treated as a not-taken branch.
- EXEC: counter decrements each cycle. On the edge where counter==0 (FU_LAT cycles after issue edge), sample the FU:
  - taken = jal | jalr | (br & fu_cmp_res).
  - If taken: redirect_valid=1 for exactly the next cycle; redirect_pc=fu_pc_jump, with bit0 forced to 0 when jalr.
  - If (jal|jalr) and rd!=0: latch wb_data=fu_pc_wb and wb_rd=rd; wb_valid=1; go WB.
  - Otherwise go IDLE.
- WB: wb_valid, wb_rd and wb_data are held stable until a cycle with wb_ack=1; that edge clears wb_valid and goes IDLE. A new issue is accepted no earlier than the following cycle.
- redirect_valid deasserts automatically the next cycle; redirect_pc holds its last value.
- flush_in (any state, sync): go IDLE and clear wb_valid and any pending redirect. If flush_in coincides with counter==0, flush wins: no redirect, no wb.
- flush_in in IDLE with issue_valid: the issue is dropped and fu_en is still asserted; the FU result is ignored.
- wb_ack outside WB is ignored. issue_valid while not ready is ignored.
- Reset mid-EXEC/WB: immediate return to reset values; no redirect is emitted.
- Latency: issue edge -> redirect_valid high FU_LAT+1 cycles later (one cycle after the sampling edge).

Optional Feature:
- Macro JUMP_RESOLVE_STATS_EN.
- Defined: adds outputs stat_taken and stat_not_taken, 32-bit each, async reset 0.
  - Increment on the sampling edge for taken/not-taken ops; flushed ops are not counted.
  - Counters wrap 0xFFFFFFFF -> 0.
- Undefined: no counters, no extra ports.

Test Plan:
- JAL, rd=1, pc_jump=0x100, pc_wb=0x14, FU_LAT=2 -> redirect_valid pulse at cycle 3 with redirect_pc=0x100; wb_valid with wb_rd=1, wb_data=0x14 held until wb_ack, then issue_ready=1.
- JALR, pc_jump=0x203 -> redirect_pc=0x202; rd=0 -> no wb_valid; returns directly to IDLE.
- BEQ, cmp_res=0 -> no redirect, no wb; issue_ready back to 1 at cycle 3. Same with cmp_res=1, pc_jump=0x40 -> redirect_pc=0x40.
- JAL with wb_ack held low 5 cycles -> wb_valid/wb_data stable for 5 cycles; issue_valid during WB is ignored (issue_ready=0).
- flush_in on the sampling cycle of a taken branch -> redirect_valid stays 0, state IDLE; rst asserted mid-EXEC -> all outputs 0 immediately.
- With JUMP_RESOLVE_STATS_EN: 3 taken + 2 not-taken + 1 flushed -> stat_taken=3, stat_not_taken=2.

Source files
------------

// File: rtl/jump_resolve.sv
// Jump/branch resolve stage: issues to the jump FU, samples its result after FU_LAT
// cycles, pulses a PC redirect for taken flow and holds the link writeback until acked.
// Optional macro JUMP_RESOLVE_STATS_EN adds taken/not-taken event counters.
module jump_resolve #(
  parameter int unsigned FU_LAT = 2,
  parameter int unsigned XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic            issue_is_jal,
  input  logic            issue_is_jalr,
  input  logic            issue_is_br,
  input  logic [4:0]      issue_rd,
  output logic            fu_en,
  input  logic [XLEN-1:0] fu_pc_jump,
  input  logic [XLEN-1:0] fu_pc_wb,
  input  logic            fu_cmp_res,
  input  logic            flush_in,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ack
`ifdef JUMP_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_not_taken
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(FU_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic       op_jal;
  logic       op_jalr;
  logic       op_br;
  logic [4:0] op_rd;

  logic       sample;
  logic       taken;
  logic       link;
  logic       commit;

  // Sampling edge is the EXEC cycle whose counter has reached zero.
  assign sample = (state == EXEC) && (count == '0);
  assign taken  = op_jal | op_jalr | (op_br & fu_cmp_res);
  assign link   = (op_jal | op_jalr) && (op_rd != '0);
  assign commit = sample && !flush_in;

  assign issue_ready = (state == IDLE);
  assign fu_en       = issue_valid & issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (issue_valid && !flush_in) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (flush_in) begin
          state_next = IDLE;
        end else if (count == '0) begin
          state_next = link ? WB : IDLE;
        end
      end
      WB: begin
        if (flush_in || wb_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      op_jal         <= 1'b0;
      op_jalr        <= 1'b0;
      op_br          <= 1'b0;
      op_rd          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      redirect_valid <= commit && taken;
      if (commit && taken) begin
        redirect_pc <= op_jalr ? {fu_pc_jump[XLEN-1:1], 1'b0} : fu_pc_jump;
      end

      // A dropped (flushed) issue still loads these; EXEC is never entered so they are inert.
      if (state == IDLE && issue_valid) begin
        op_jal  <= issue_is_jal;
        op_jalr <= issue_is_jalr;
        op_br   <= issue_is_br;
        op_rd   <= issue_rd;
        count   <= LAT_M1;
      end else if (state == EXEC && count != '0) begin
        count <= count - 4'd1;
      end

      if (flush_in) begin
        wb_valid <= 1'b0;
      end else if (commit && link) begin
        wb_valid <= 1'b1;
        wb_rd    <= op_rd;
        wb_data  <= fu_pc_wb;
      end else if (state == WB && wb_ack) begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef JUMP_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (commit) begin
      if (taken) begin
        stat_taken <= stat_taken + 32'd1;
      end else begin
        stat_not_taken <= stat_not_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jump_resolve.sv
// Scoreboard bench for jump_resolve: driver pushes expected redirect/writeback events,
// an independent monitor pops and compares them as the DUT presents them.
module tb_jump_resolve;

  localparam int FU_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        issue_is_jal = 1'b0;
  logic        issue_is_jalr = 1'b0;
  logic        issue_is_br = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        fu_en;
  logic [31:0] fu_pc_jump = '0;
  logic [31:0] fu_pc_wb = '0;
  logic        fu_cmp_res = 1'b0;
  logic        flush_in = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ack = 1'b0;
`ifdef JUMP_RESOLVE_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
`endif

  jump_resolve #(.FU_LAT(FU_LAT), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_is_jal(issue_is_jal), .issue_is_jalr(issue_is_jalr), .issue_is_br(issue_is_br),
    .issue_rd(issue_rd), .fu_en(fu_en),
    .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb), .fu_cmp_res(fu_cmp_res),
    .flush_in(flush_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ack(wb_ack)
`ifdef JUMP_RESOLVE_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int cyc; logic [31:0] pc; } redir_t;
  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wbe_t;
  redir_t rq[$];
  wbe_t   wq[$];

  int tests = 0;
  int fails = 0;
  int m_taken = 0;
  int m_not_taken = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT presents an event.
  logic        prev_wbv = 1'b0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_wbv = 1'b0;
    end else begin
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        check("redirect_missing", 64'(rq[0].cyc), 64'(cyc));
        void'(rq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        check("wb_missing", 64'(wq[0].cyc), 64'(cyc));
        void'(wq.pop_front());
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          check("redirect_unexpected", 64'(redirect_valid), 64'd0);
        end else begin
          redir_t e;
          e = rq.pop_front();
          check("redirect_cycle", 64'(cyc), 64'(e.cyc));
          check("redirect_pc", 64'(redirect_pc), 64'(e.pc));
        end
      end
      if (wb_valid && !prev_wbv) begin
        if (wq.size() == 0) begin
          check("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          wbe_t w;
          w = wq.pop_front();
          check("wb_cycle", 64'(cyc), 64'(w.cyc));
          check("wb_rd", 64'(wb_rd), 64'(w.rd));
          check("wb_data", 64'(wb_data), 64'(w.data));
        end
      end else if (wb_valid && prev_wbv) begin
        check("wb_rd_stable", 64'(wb_rd), 64'(last_rd));
        check("wb_data_stable", 64'(wb_data), 64'(last_data));
      end
      prev_wbv  = wb_valid;
      last_rd   = wb_rd;
      last_data = wb_data;
    end
  end

  // kind: 0 JAL, 1 JALR, 2 branch, 3 no flag. fmode: 0 none, 1 flush on sampling cycle, 2 flush at issue.
  task automatic do_op(input int kind, input logic [4:0] rd, input logic [31:0] pj,
                       input logic [31:0] pw, input logic cmp, input int fmode, input int ack_dly);
    int g;
    int iss;
    logic jal, jalr, br, tk, lnk;
    g = 0;
    while (!issue_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_issue", 64'(issue_ready), 64'd1);
    jal  = (kind == 0);
    jalr = (kind == 1);
    br   = (kind == 2);
    issue_valid = 1'b1; issue_is_jal = jal; issue_is_jalr = jalr; issue_is_br = br;
    issue_rd = rd; fu_pc_jump = pj; fu_pc_wb = pw; fu_cmp_res = cmp;
    flush_in = (fmode == 2);
    #1 check("fu_en", 64'(fu_en), 64'd1);
    @(negedge clk);
    iss = cyc;
    issue_valid = 1'b0;
    flush_in = 1'b0;
    if (fmode == 2) begin
      check("ready_after_drop", 64'(issue_ready), 64'd1);
      return;
    end
    check("ready_in_exec", 64'(issue_ready), 64'd0);
    tk  = jal || jalr || (br && cmp);
    lnk = (jal || jalr) && (rd != 5'd0);
    if (fmode == 0) begin
      if (tk) begin
        redir_t e;
        e.cyc = iss + FU_LAT;
        e.pc  = jalr ? {pj[31:1], 1'b0} : pj;
        rq.push_back(e);
        m_taken++;
      end else begin
        m_not_taken++;
      end
      if (lnk) begin
        wbe_t w;
        w.cyc = iss + FU_LAT; w.rd = rd; w.data = pw;
        wq.push_back(w);
      end
    end
    while (cyc < iss + FU_LAT - 1) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_is_jal = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom);
      wb_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("ready_in_exec", 64'(issue_ready), 64'd0);
    end
    issue_valid = 1'b0;
    wb_ack = 1'b0;
    flush_in = (fmode == 1);
    @(negedge clk);
    flush_in = 1'b0;
    if (lnk && fmode == 0) begin
      check("ready_in_wb", 64'(issue_ready), 64'd0);
      repeat (ack_dly) begin
        issue_valid = 1'($urandom_range(0, 1));
        fu_pc_wb = $urandom;
        @(negedge clk);
        check("ready_in_wb", 64'(issue_ready), 64'd0);
      end
      issue_valid = 1'b0;
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
    end
    check("ready_after_op", 64'(issue_ready), 64'd1);
  endtask

  initial begin
    #1;
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(issue_ready), 64'd1);

    do_op(0, 5'd1, 32'h100, 32'h14, 1'b0, 0, 3);
    do_op(1, 5'd0, 32'h203, 32'h8, 1'b0, 0, 0);
    do_op(2, 5'd3, 32'h80, 32'h8, 1'b0, 0, 0);
    do_op(2, 5'd3, 32'h40, 32'h8, 1'b1, 0, 0);
    do_op(0, 5'd2, 32'h300, 32'h44, 1'b0, 0, 5);
    do_op(2, 5'd0, 32'h60, 32'h4, 1'b1, 1, 0);
    do_op(1, 5'd7, 32'h555, 32'h70, 1'b0, 1, 0);
    do_op(0, 5'd4, 32'h90, 32'h94, 1'b0, 2, 0);
    do_op(3, 5'd9, 32'h1234, 32'h10, 1'b1, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      do_op($urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, $urandom, 1'($urandom_range(0, 1)),
            (r == 0) ? 1 : (r == 1) ? 2 : 0,
            $urandom_range(0, 4));
    end

    repeat (4) @(negedge clk);
`ifdef JUMP_RESOLVE_STATS_EN
    check("stat_taken", 64'(stat_taken), 64'(m_taken));
    check("stat_not_taken", 64'(stat_not_taken), 64'(m_not_taken));
`endif

    // Reset in the middle of EXEC: outputs clear at once and no redirect follows.
    issue_valid = 1'b1; issue_is_jal = 1'b1; issue_is_jalr = 1'b0; issue_is_br = 1'b0;
    issue_rd = 5'd5; fu_pc_jump = 32'hABC; fu_pc_wb = 32'h77;
    @(negedge clk);
    issue_valid = 1'b0;
    check("ready_in_exec_pre_rst", 64'(issue_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("midrst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("midrst_wb_valid", 64'(wb_valid), 64'd0);
    check("midrst_wb_rd", 64'(wb_rd), 64'd0);
    check("midrst_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (FU_LAT + 3) @(negedge clk);
    check("ready_after_midrst", 64'(issue_ready), 64'd1);
    check("redirect_queue_drained", 64'(rq.size()), 64'd0);
    check("wb_queue_drained", 64'(wq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
